// File: rtl/eth_pkg.sv
// eth_pkg: shared types and defaults for the Ethernet receive path.
// Holds the frame FIFO FSM encodings and stream/statistic widths.
package eth_pkg;

  localparam int ETH_DATA_W = 8;
  localparam int STAT_W     = 16;

  typedef enum logic {
    WR_ACCEPT,
    WR_DROP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_e;

endpackage

// File: rtl/bram.sv
// bram: single-clock dual-port block RAM, one write and one read port.
// Ports: clk, rst_n (sync, clears read register), we/waddr/wdata,
//        re/raddr, rdata (registered, holds when re is low).
module bram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: store-and-forward MAC RX frame buffer; only error-free
// frames that fit are replayed downstream on a ready/valid byte stream.
// Ports: clk, rst_n (sync, active low);
//   i_s_valid/i_s_data/i_s_last/i_s_err : MAC byte stream, no backpressure
//   o_m_valid/o_m_data/o_m_last, i_m_ready : committed frame output
//   o_frame_cnt : committed frames not yet fully read
//   o_drop : one-cycle pulse per discarded frame
//   o_frames_ok/o_frames_drop : saturating counters, built only when
//   RX_FRAME_FIFO_STATS_EN is defined, otherwise tied to zero.
module rx_frame_fifo
  import eth_pkg::*;
#(
  parameter int DATA_W     = ETH_DATA_W,
  parameter int DEPTH      = 2048,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int MAX_FRAMES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_s_valid,
  input  logic [DATA_W-1:0]            i_s_data,
  input  logic                         i_s_last,
  input  logic                         i_s_err,
  output logic                         o_m_valid,
  output logic [DATA_W-1:0]            o_m_data,
  output logic                         o_m_last,
  input  logic                         i_m_ready,
  output logic [$clog2(MAX_FRAMES):0]  o_frame_cnt,
  output logic                         o_drop,
  output logic [STAT_W-1:0]            o_frames_ok,
  output logic [STAT_W-1:0]            o_frames_drop
);

  localparam int PW    = ADDR_W + 1;
  localparam int LQ_AW = $clog2(MAX_FRAMES);
  localparam int CW    = LQ_AW + 1;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [CW-1:0] MAXF_P  = CW'(MAX_FRAMES);

  // Input register stage: isolates the MAC timing from the
  // pointer arithmetic and full detection.
  logic              in_vld;
  logic              in_last;
  logic              in_err;
  logic [DATA_W-1:0] in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_vld  <= 1'b0;
      in_last <= 1'b0;
      in_err  <= 1'b0;
      in_data <= '0;
    end else begin
      in_vld  <= i_s_valid;
      in_last <= i_s_valid & i_s_last;
      in_err  <= i_s_valid & i_s_last & i_s_err;
      in_data <= i_s_data;
    end
  end

  wr_state_e wr_state;
  rd_state_e rd_state;

  logic [PW-1:0] wr_start;
  logic [PW-1:0] wr_cur;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_rem;
  logic [PW-1:0] used;
  logic [PW-1:0] wr_len;

  logic [LQ_AW-1:0] lq_wp;
  logic [LQ_AW-1:0] lq_rp;
  logic [PW-1:0]    lq_mem [MAX_FRAMES];

  logic full;
  logic lq_full;
  logic acc;
  logic bad_eof;
  logic commit;
  logic wr_en;
  logic rd_en;
  logic done;
  logic pop;

  assign used    = wr_cur - rd_ptr;
  assign full    = (used == DEPTH_P);
  assign wr_len  = wr_cur - wr_start + PW'(1);

  // Capacity is counted in committed-but-unread frames, including
  // the one currently being replayed.
  assign lq_full = (o_frame_cnt == MAXF_P);

  assign acc     = in_vld && (wr_state == WR_ACCEPT);
  assign bad_eof = acc && !full && in_last
                 && (in_err || lq_full);
  assign commit  = acc && !full && in_last
                 && !in_err && !lq_full;
  assign wr_en   = acc && !full && !bad_eof;

  assign rd_en = (rd_state == RD_RUN)
               && (rd_rem != '0)
               && (!o_m_valid || i_m_ready);
  assign done  = o_m_valid && o_m_last && i_m_ready;

  // A queued frame is popped from idle, or directly on the edge the
  // previous frame's last byte is accepted to keep a single gap cycle.
  assign pop = ((rd_state == RD_IDLE) && (o_frame_cnt != '0))
             || ((rd_state == RD_RUN) && done
                 && (o_frame_cnt > CW'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state <= WR_ACCEPT;
      wr_start <= '0;
      wr_cur   <= '0;
      o_drop   <= 1'b0;
    end else begin
      o_drop <= 1'b0;
      unique case (wr_state)
        WR_ACCEPT: begin
          if (in_vld) begin
            if (full) begin
              wr_cur <= wr_start;
              o_drop <= 1'b1;
              if (!in_last) begin
                wr_state <= WR_DROP;
              end
            end else if (bad_eof) begin
              wr_cur <= wr_start;
              o_drop <= 1'b1;
            end else if (commit) begin
              wr_cur   <= wr_cur + 1'b1;
              wr_start <= wr_cur + 1'b1;
            end else begin
              wr_cur <= wr_cur + 1'b1;
            end
          end
        end
        WR_DROP: begin
          if (in_vld && in_last) begin
            wr_state <= WR_ACCEPT;
          end
        end
        default: wr_state <= WR_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      lq_mem[lq_wp] <= wr_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lq_wp <= '0;
    end else if (commit) begin
      lq_wp <= lq_wp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_frame_cnt <= '0;
    end else if (commit && !done) begin
      o_frame_cnt <= o_frame_cnt + 1'b1;
    end else if (done && !commit) begin
      o_frame_cnt <= o_frame_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state  <= RD_IDLE;
      rd_rem    <= '0;
      rd_ptr    <= '0;
      lq_rp     <= '0;
      o_m_valid <= 1'b0;
      o_m_last  <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_m_valid <= 1'b1;
        o_m_last  <= (rd_rem == PW'(1));
      end else if (i_m_ready) begin
        o_m_valid <= 1'b0;
        o_m_last  <= 1'b0;
      end
      unique case (rd_state)
        RD_IDLE: begin
          if (pop) begin
            rd_rem   <= lq_mem[lq_rp];
            lq_rp    <= lq_rp + 1'b1;
            rd_state <= RD_RUN;
          end
        end
        RD_RUN: begin
          if (pop) begin
            rd_rem <= lq_mem[lq_rp];
            lq_rp  <= lq_rp + 1'b1;
          end else begin
            if (rd_en) begin
              rd_rem <= rd_rem - 1'b1;
            end
            if (done) begin
              rd_state <= RD_IDLE;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  bram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_cur[ADDR_W-1:0]),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (o_m_data)
  );

`ifdef RX_FRAME_FIFO_STATS_EN
  logic [STAT_W-1:0] ok_q;
  logic [STAT_W-1:0] drop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_q   <= '0;
      drop_q <= '0;
    end else begin
      if (commit && (ok_q != '1)) begin
        ok_q <= ok_q + 1'b1;
      end
      if (o_drop && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign o_frames_ok   = ok_q;
  assign o_frames_drop = drop_q;
`else
  assign o_frames_ok   = '0;
  assign o_frames_drop = '0;
`endif

endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb_rx_frame_fifo: directed + randomized checks of rx_frame_fifo
// against a frame-level reference model (byte queue + occupancy).
module tb_rx_frame_fifo;

  localparam int DEPTH = 128;
  localparam int MAXF  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_s_valid;
  logic [7:0]  i_s_data;
  logic        i_s_last;
  logic        i_s_err;
  logic        o_m_valid;
  logic [7:0]  o_m_data;
  logic        o_m_last;
  logic        i_m_ready;
  logic [3:0]  o_frame_cnt;
  logic        o_drop;
  logic [15:0] o_frames_ok;
  logic [15:0] o_frames_drop;

  rx_frame_fifo #(
    .DATA_W     (8),
    .DEPTH      (DEPTH),
    .MAX_FRAMES (MAXF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_s_valid     (i_s_valid),
    .i_s_data      (i_s_data),
    .i_s_last      (i_s_last),
    .i_s_err       (i_s_err),
    .o_m_valid     (o_m_valid),
    .o_m_data      (o_m_data),
    .o_m_last      (o_m_last),
    .i_m_ready     (i_m_ready),
    .o_frame_cnt   (o_frame_cnt),
    .o_drop        (o_drop),
    .o_frames_ok   (o_frames_ok),
    .o_frames_drop (o_frames_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } ob_t;

  ob_t exp_q[$];
  int  occ      = 0;
  int  frames   = 0;
  int  m_ok     = 0;
  int  m_drop   = 0;
  int  n_drop   = 0;
  int  drop_seen = 0;
  int  chk_cnt  = 0;
  int  pass_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;

  always @(negedge clk) begin
    ob_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (o_drop) drop_seen++;
      if (hold_v) begin
        chk("hold_valid", o_m_valid, 1);
        chk("hold_data", o_m_data, hold_d);
        chk("hold_last", o_m_last, hold_l);
      end
      if (o_m_valid && i_m_ready) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", o_m_data, e.d);
          chk("out_last", o_m_last, e.l);
          occ--;
          if (e.l) frames--;
        end
        hold_v = 1'b0;
      end else begin
        hold_v = o_m_valid;
        hold_d = o_m_data;
        hold_l = o_m_last;
      end
    end
  end

  // A frame is admitted iff error-free, it fits beside the committed
  // unread bytes, and fewer than MAXF frames are pending.
  task automatic send_frame(input int len, input bit rnd, input bit err);
    ob_t fr[$];
    logic [7:0] b;
    bit ok;
    ok = !err && (occ + len <= DEPTH) && (frames < MAXF);
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      @(posedge clk); #1;
      i_s_valid = 1'b1;
      i_s_data  = b;
      i_s_last  = (i == len - 1);
      i_s_err   = (i == len - 1) ? err : 1'($urandom);
      fr.push_back('{b, (i == len - 1)});
    end
    if (ok) begin
      foreach (fr[k]) exp_q.push_back(fr[k]);
      occ += len;
      frames++;
      m_ok++;
    end else begin
      m_drop++;
      n_drop++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_s_valid = 1'b0;
      i_s_last  = 1'b0;
      i_s_err   = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int budget,
                       input bit rnd_ready);
    int n = 0;
    while ((exp_q.size() != 0 || o_frame_cnt != 0) && n < budget) begin
      @(posedge clk); #1;
      i_m_ready = rnd_ready ? 1'($urandom) : 1'b1;
      n++;
    end
    i_m_ready = 1'b1;
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_fcnt"}, o_frame_cnt, frames);
  endtask

  task automatic chk_stats(input string tag);
`ifdef RX_FRAME_FIFO_STATS_EN
    chk({tag, "_ok"}, o_frames_ok, m_ok);
    chk({tag, "_drop"}, o_frames_drop, m_drop);
`else
    chk({tag, "_ok"}, o_frames_ok, 0);
    chk({tag, "_drop"}, o_frames_drop, 0);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    i_s_valid = 1'b0;
    i_s_data  = '0;
    i_s_last  = 1'b0;
    i_s_err   = 1'b0;
    i_m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_m_valid, 0);
    chk("rst_last", o_m_last, 0);
    chk("rst_data", o_m_data, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    chk("rst_drop", o_drop, 0);
    chk_stats("rst");
    rst_n = 1'b1;

    // errored frame then a good one
    i_m_ready = 1'b1;
    send_frame(20, 0, 1);
    send_frame(10, 1, 0);
    idle(4);
    drain("err", 300, 0);
    chk("err_drops", drop_seen, n_drop);
    chk_stats("err");

    // 64-byte good frame with first-byte latency
    send_frame(64, 0, 0);
    idle(1);
    chk("lat_n0_valid", o_m_valid, 0);
    idle(1);
    chk("lat_n1_fcnt", o_frame_cnt, 1);
    chk("lat_n1_valid", o_m_valid, 0);
    idle(1);
    chk("lat_n2_valid", o_m_valid, 0);
    idle(1);
    chk("lat_n3_valid", o_m_valid, 1);
    chk("lat_n3_data", o_m_data, 0);
    chk("lat_n3_last", o_m_last, 0);
    drain("good", 300, 0);

    // overflow of the second frame, then a large frame fits
    i_m_ready = 1'b0;
    send_frame(80, 0, 0);
    send_frame(80, 1, 0);
    idle(5);
    chk("ovf_drops", drop_seen, n_drop);
    chk("ovf_fcnt", o_frame_cnt, frames);
    drain("ovf", 400, 0);
    send_frame(120, 1, 0);
    idle(2);
    drain("ovf3", 400, 0);

    // exactly DEPTH bytes fits, DEPTH+1 drops
    send_frame(DEPTH, 1, 0);
    idle(2);
    drain("len_max", 400, 0);
    send_frame(DEPTH + 1, 1, 0);
    idle(5);
    drain("len_over", 50, 0);
    chk("len_drops", drop_seen, n_drop);
    chk_stats("len");

    // length queue full
    i_m_ready = 1'b0;
    for (int k = 0; k < MAXF + 1; k++) send_frame(4, 1, 0);
    idle(5);
    chk("lq_fcnt", o_frame_cnt, MAXF);
    chk("lq_drops", drop_seen, n_drop);
    drain("lq", 400, 0);

    // backpressure on a 100-byte frame
    i_m_ready = 1'b0;
    send_frame(100, 1, 0);
    idle(3);
    drain("bp", 1000, 1);

    // randomized frames
    i_m_ready = 1'b0;
    for (int k = 0; k < 6; k++)
      send_frame($urandom_range(1, 15), 1, $urandom_range(0, 3) == 0);
    idle(5);
    chk("rnd_drops", drop_seen, n_drop);
    chk("rnd_fcnt", o_frame_cnt, frames);
    drain("rnd", 1000, 1);
    chk_stats("rnd");

    // reset mid input frame and mid output frame
    i_m_ready = 1'b0;
    send_frame(60, 1, 0);
    idle(4);
    i_m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      i_s_valid = 1'b1;
      i_s_data  = 8'($urandom);
      i_s_last  = 1'b0;
      i_s_err   = 1'b0;
    end
    rst_n     = 1'b0;
    i_s_valid = 1'b0;
    @(posedge clk); #1;
    chk("mrst_valid", o_m_valid, 0);
    chk("mrst_last", o_m_last, 0);
    chk("mrst_data", o_m_data, 0);
    chk("mrst_fcnt", o_frame_cnt, 0);
    chk("mrst_drop", o_drop, 0);
    exp_q.delete();
    occ    = 0;
    frames = 0;
    m_ok   = 0;
    m_drop = 0;
    rst_n  = 1'b1;
    chk_stats("mrst");
    send_frame(8, 1, 0);
    idle(2);
    drain("post_rst", 200, 0);
    chk("post_rst_drops", drop_seen, n_drop);
    chk_stats("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
